// File: rtl/dcp_mem_responder_if.sv
// Accelerator memory-port bundle: line-read requests, tagged line responses and the
// backing-array preload port, as seen by dcp_mem_responder.
interface dcp_mem_responder_if #(
  parameter int DEPTH = 4,
  parameter int LINES = 64
);
  localparam int PADDR_W = 40;
  localparam int DATA_W  = 512;
  localparam int IDX_W   = $clog2(LINES);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               mem_req_val;
  logic               mem_req_rdy;
  logic [5:0]         mem_req_transid;
  logic [PADDR_W-1:0] mem_req_addr;
  logic               mem_resp_val;
  logic [5:0]         mem_resp_transid;
  logic [DATA_W-1:0]  mem_resp_data;
  logic               preload_val;
  logic [IDX_W-1:0]   preload_idx;
  logic [DATA_W-1:0]  preload_data;
  logic               oor;
  logic [CNT_W-1:0]   pending;

  modport master (
    output mem_req_val, mem_req_transid, mem_req_addr,
    output preload_val, preload_idx, preload_data,
    input  mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data, oor, pending
  );

  modport slave (
    input  mem_req_val, mem_req_transid, mem_req_addr,
    input  preload_val, preload_idx, preload_data,
    output mem_req_rdy, mem_resp_val, mem_resp_transid, mem_resp_data, oor, pending
  );
endinterface

// File: rtl/dcp_mem_responder.sv
// Memory-side responder: queues line reads, answers each in order no earlier than
// LATENCY cycles after accept, from a preloadable line array.
module dcp_mem_responder #(
  parameter int DEPTH   = 4,
  parameter int LINES   = 64,
  parameter int LATENCY = 4
) (
  input logic                clk,
  input logic                rst,
  dcp_mem_responder_if.slave bus
);
  localparam int PADDR_W = 40;
  localparam int DATA_W  = 512;
  localparam int IDX_W   = $clog2(LINES);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  // Queued entries never get older than LATENCY+DEPTH, so this width cannot alias.
  localparam int TIME_W  = $clog2(LATENCY + DEPTH) + 1;

  typedef struct packed {
    logic [5:0]        transid;
    logic [IDX_W-1:0]  idx;
    logic              oor;
    logic [TIME_W-1:0] stamp;
  } entry_t;

  logic [DATA_W-1:0] lines [LINES];
  entry_t            queue [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TIME_W-1:0] now;
  logic [TIME_W-1:0] age;
  entry_t            head, incoming;
  logic              room, accept, issue;
  logic              unused_offset;

  assign room            = count < CNT_W'(DEPTH);
  assign bus.mem_req_rdy = !rst && room;
  assign bus.pending     = count;
  // Reset is left out of the internal accept: a payload written during reset is
  // never visible because the pointers and count are held cleared.
  assign accept          = bus.mem_req_val && room;
  assign head            = queue[rd_ptr];
  assign age             = now - head.stamp;
  assign issue           = (count != '0) && (age >= TIME_W'(LATENCY));
  assign unused_offset   = ^bus.mem_req_addr[5:0];

  always_comb begin
    incoming.transid = bus.mem_req_transid;
    incoming.idx     = bus.mem_req_addr[6 +: IDX_W];
    incoming.oor     = |bus.mem_req_addr[PADDR_W-1:6+IDX_W];
    incoming.stamp   = now;
  end

  // NOTE: the line array and queue payload are plain storage without reset; only
  // the control state below is reset, so line contents survive rst.
  always_ff @(posedge clk) begin
    if (bus.preload_val) lines[bus.preload_idx] <= bus.preload_data;
    if (accept)          queue[wr_ptr]          <= incoming;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now                  <= '0;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      bus.mem_resp_val     <= 1'b0;
      bus.mem_resp_transid <= '0;
      bus.mem_resp_data    <= '0;
      bus.oor              <= 1'b0;
    end else begin
      now <= now + TIME_W'(1);
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (issue)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !issue)      count <= count + CNT_W'(1);
      else if (issue && !accept) count <= count - CNT_W'(1);
      bus.mem_resp_val <= issue;
      bus.oor          <= issue && head.oor;
      // Read happens at the issue edge, so a same-edge preload returns old data.
      if (issue) begin
        bus.mem_resp_transid <= head.transid;
        bus.mem_resp_data    <= head.oor ? '0 : lines[head.idx];
      end
    end
  end
endmodule

// File: tb/tb_dcp_mem_responder.sv
// Self-checking bench for dcp_mem_responder: table vectors, directed corner sequences
// and randomized traffic against a schedule-based reference model.
module tb_dcp_mem_responder;
  localparam int DEPTH   = 4;
  localparam int LINES   = 64;
  localparam int LATENCY = 4;

  typedef struct {
    bit          val;
    logic [5:0]  tid;
    logic [39:0] addr;
    bit          pl;
    logic [5:0]  pl_idx;
    logic [511:0] pl_data;
  } stim_t;

  typedef struct {
    logic [5:0] tid;
    int         idx;
    bit         oor;
    int         when;
  } exp_t;

  typedef struct {
    logic [5:0]  tid;
    logic [39:0] addr;
    bit          oor;
    int          line;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcp_mem_responder_if #(.DEPTH(DEPTH), .LINES(LINES)) m ();
  dcp_mem_responder_if #(.DEPTH(2), .LINES(LINES)) s ();

  dcp_mem_responder #(.DEPTH(DEPTH), .LINES(LINES), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .bus(m.slave));
  dcp_mem_responder #(.DEPTH(2), .LINES(LINES), .LATENCY(4)) dut2 (
    .clk(clk), .rst(rst), .bus(s.slave));

  int           n_checks = 0;
  int           n_errors = 0;
  int           edge_no  = 0;
  int           last_sched = -1000;
  logic [511:0] shadow [LINES];
  exp_t         mq [$];
  bit           obs_val;
  logic [5:0]   obs_tid;
  logic [511:0] obs_data;
  bit           obs_oor;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int line);
    logic [511:0] p;
    for (int w = 0; w < 16; w++) p[w*32 +: 32] = {8'hA5, 8'(line), 16'(w * 4099 + line)};
    return p;
  endfunction

  function automatic stim_t idle();
    stim_t st;
    st.val = 1'b0; st.tid = '0; st.addr = '0;
    st.pl = 1'b0; st.pl_idx = '0; st.pl_data = '0;
    return st;
  endfunction

  function automatic stim_t req(input logic [5:0] tid, input logic [39:0] addr);
    stim_t st = idle();
    st.val = 1'b1; st.tid = tid; st.addr = addr;
    return st;
  endfunction

  // One clock of the main DUT: drive, advance the schedule model, then compare.
  task automatic cycle(input stim_t st);
    bit           exp_rdy, acc, due;
    exp_t         e, hd;
    logic [511:0] exp_data;
    m.mem_req_val = st.val; m.mem_req_transid = st.tid; m.mem_req_addr = st.addr;
    m.preload_val = st.pl;  m.preload_idx = st.pl_idx;  m.preload_data = st.pl_data;
    exp_rdy = (mq.size() < DEPTH);
    check("req_rdy", 512'(m.mem_req_rdy), 512'(exp_rdy));
    acc = st.val && exp_rdy;
    @(posedge clk);
    edge_no++;
    due = (mq.size() > 0) && (mq[0].when == edge_no);
    exp_data = '0;
    hd.tid = '0; hd.oor = 1'b0;
    if (due) begin
      hd = mq.pop_front();
      if (!hd.oor) exp_data = shadow[hd.idx];
    end
    if (st.pl) shadow[st.pl_idx] = st.pl_data;
    if (acc) begin
      e.tid  = st.tid;
      e.idx  = int'((st.addr / 64) % LINES);
      e.oor  = (st.addr >= 40'(LINES * 64));
      e.when = (edge_no + LATENCY > last_sched + 1) ? edge_no + LATENCY : last_sched + 1;
      last_sched = e.when;
      mq.push_back(e);
    end
    @(negedge clk);
    obs_val = m.mem_resp_val; obs_tid = m.mem_resp_transid;
    obs_data = m.mem_resp_data; obs_oor = m.oor;
    check("resp_val", 512'(m.mem_resp_val), 512'(due));
    check("resp_oor", 512'(m.oor), 512'(due && hd.oor));
    if (due) begin
      check("resp_transid", 512'(m.mem_resp_transid), 512'(hd.tid));
      check("resp_data", m.mem_resp_data, exp_data);
    end
    check("pending", 512'(m.pending), 512'(mq.size()));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mq.size() > 0; i++) cycle(idle());
  endtask

  task automatic req_and_wait(input logic [5:0] tid, input logic [39:0] addr, output int lat);
    cycle(req(tid, addr));
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(idle());
      if (obs_val) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("resp_timeout", 512'(0), 512'(1));
  endtask

  task automatic do_reset();
    m.mem_req_val = 1'b0; m.preload_val = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_pending", 512'(m.pending), 512'(0));
    check("rst_resp_val", 512'(m.mem_resp_val), 512'(0));
    check("rst_rdy_low", 512'(m.mem_req_rdy), 512'(0));
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    last_sched = -1000;
    #1;
    check("rst_rdy_high", 512'(m.mem_req_rdy), 512'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t         vecs [6];
    int           lat, seen;
    logic [5:0]   tids [$];
    logic [5:0]   d2_acc [$];
    logic [5:0]   d2_resp [$];
    bit           exp_acc [10];
    logic [511:0] newdata;
    stim_t        st;

    vecs[0] = '{tid: 6'd5,  addr: 40'hC0,          oor: 1'b0, line: 3};
    vecs[1] = '{tid: 6'd9,  addr: 40'h1000,        oor: 1'b1, line: 0};
    vecs[2] = '{tid: 6'd10, addr: 40'h1C7,         oor: 1'b0, line: 7};
    vecs[3] = '{tid: 6'd63, addr: 40'hFFF,         oor: 1'b0, line: 63};
    vecs[4] = '{tid: 6'd0,  addr: 40'h80_0000_0040, oor: 1'b1, line: 1};
    vecs[5] = '{tid: 6'd33, addr: 40'h0,           oor: 1'b0, line: 0};
    exp_acc = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    m.mem_req_val = 1'b0; m.mem_req_transid = '0; m.mem_req_addr = '0;
    m.preload_val = 1'b0; m.preload_idx = '0; m.preload_data = '0;
    s.mem_req_val = 1'b0; s.mem_req_transid = '0; s.mem_req_addr = '0;
    s.preload_val = 1'b0; s.preload_idx = '0; s.preload_data = '0;

    // Reset values
    @(negedge clk);
    check("reset_resp_val", 512'(m.mem_resp_val), 512'(0));
    check("reset_transid", 512'(m.mem_resp_transid), 512'(0));
    check("reset_data", m.mem_resp_data, 512'(0));
    check("reset_oor", 512'(m.oor), 512'(0));
    check("reset_pending", 512'(m.pending), 512'(0));
    check("reset_rdy", 512'(m.mem_req_rdy), 512'(0));
    rst = 1'b0;
    #1;
    check("release_rdy", 512'(m.mem_req_rdy), 512'(1));

    for (int i = 0; i < LINES; i++) begin
      st = idle();
      st.pl = 1'b1; st.pl_idx = 6'(i); st.pl_data = pat(i);
      cycle(st);
    end

    // Table-driven address/range vectors
    foreach (vecs[i]) begin
      req_and_wait(vecs[i].tid, vecs[i].addr, lat);
      check("vec_latency", 512'(lat), 512'(LATENCY));
      check("vec_transid", 512'(obs_tid), 512'(vecs[i].tid));
      check("vec_oor", 512'(obs_oor), 512'(vecs[i].oor));
      check("vec_data", obs_data, vecs[i].oor ? 512'(0) : pat(vecs[i].line));
    end

    // Back-to-back: four requests fill the queue, a fifth is held off
    for (int i = 1; i <= 4; i++) cycle(req(6'(i), 40'(i * 64)));
    check("full_rdy_low", 512'(m.mem_req_rdy), 512'(0));
    tids.delete();
    cycle(req(6'd60, 40'h40));
    if (obs_val) tids.push_back(obs_tid);
    check("full_rdy_rises", 512'(m.mem_req_rdy), 512'(1));
    for (int i = 0; i < 3; i++) begin
      cycle(idle());
      if (obs_val) tids.push_back(obs_tid);
    end
    check("b2b_count", 512'(tids.size()), 512'(4));
    for (int i = 0; i < 4 && i < tids.size(); i++)
      check("b2b_order", 512'(tids[i]), 512'(i + 1));
    drain();

    // Preload to line 7 at the very edge its response issues
    newdata = {16{32'h5A5A_1234}};
    cycle(req(6'd11, 40'h1C0));
    for (int i = 0; i < 3; i++) cycle(idle());
    st = idle();
    st.pl = 1'b1; st.pl_idx = 6'd7; st.pl_data = newdata;
    cycle(st);
    check("rbw_val", 512'(obs_val), 512'(1));
    check("rbw_old_data", obs_data, pat(7));
    req_and_wait(6'd12, 40'h1C0, lat);
    check("rbw_new_data", obs_data, newdata);

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) cycle(req(6'(20 + i), 40'(i * 64)));
    do_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(idle());
      if (obs_val) seen++;
    end
    check("flush_no_resp", 512'(seen), 512'(0));
    req_and_wait(6'd42, 40'h80, lat);
    check("post_reset_latency", 512'(lat), 512'(LATENCY));
    check("post_reset_transid", 512'(obs_tid), 512'(42));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int b;
      st = idle();
      st.val = ($urandom_range(0, 9) < 7);
      st.tid = 6'($urandom);
      st.addr = 40'($urandom_range(0, LINES - 1) * 64 + $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(12, 39);
        st.addr[b] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) begin
        st.pl = 1'b1;
        st.pl_idx = 6'($urandom);
        for (int w = 0; w < 16; w++) st.pl_data[w*32 +: 32] = $urandom;
      end
      cycle(st);
    end
    drain();

    // DEPTH=2 instance: val held high for ten edges
    for (int i = 0; i < 10; i++) begin
      s.mem_req_val = 1'b1;
      s.mem_req_transid = 6'(i);
      check("d2_rdy", 512'(s.mem_req_rdy), 512'(exp_acc[i]));
      if (exp_acc[i]) d2_acc.push_back(6'(i));
      tick();
      check("d2_pending_max", 512'(s.pending <= 2), 512'(1));
      if (s.mem_resp_val) d2_resp.push_back(s.mem_resp_transid);
    end
    s.mem_req_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s.mem_resp_val) d2_resp.push_back(s.mem_resp_transid);
    end
    check("d2_resp_count", 512'(d2_resp.size()), 512'(4));
    for (int i = 0; i < d2_acc.size() && i < d2_resp.size(); i++)
      check("d2_resp_order", 512'(d2_resp[i]), 512'(d2_acc[i]));
    check("d2_pending_end", 512'(s.pending), 512'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
